// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_operand_stage_pkg
// Brief  : Shared constants for decoder, operand stage and ALU.
// Rev    : 1.0  initial release
// ============================================================================
package alu_operand_stage_pkg;

  localparam int CPU_XLEN = 32;
  localparam int CPU_NREG = 32;
  localparam int REG_AW   = 5;
  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_EQ   = 4'd10, ALU_NE   = 4'd11,
    ALU_LT   = 4'd12, ALU_GE   = 4'd13, ALU_LTU  = 4'd14, ALU_GEU  = 4'd15
  } alu_op_e;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module : reg_file_2r1w
// Brief  : 2-read/1-write register file, x0 hardwired to zero, write-first bypass.
// Rev    : 1.0  initial release
// ============================================================================
module reg_file_2r1w
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int NREG = CPU_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Write-first: a same-cycle write-back is visible to the reader immediately.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0)
      rdata1_o = (wb_en_i && (wb_addr_i == raddr1_i)) ? wb_data_i : mem_q[raddr1_i];
    if (raddr2_i != '0)
      rdata2_o = (wb_en_i && (wb_addr_i == raddr2_i)) ? wb_data_i : mem_q[raddr2_i];
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_operand_stage
// Brief  : Operand fetch, RAW scoreboard and registered valid/ready ALU slot.
// Rev    : 1.0  initial release
// ============================================================================
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN = CPU_XLEN,
  parameter int NREG = CPU_NREG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_AW-1:0]   rs1_addr,
  input  logic [REG_AW-1:0]   rs2_addr,
  input  logic [REG_AW-1:0]   rd_addr,
  input  logic                rd_we,
  input  logic                a_sel,
  input  logic                b_sel,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     imm,
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     A,
  output logic [XLEN-1:0]     B,
  output logic [ALU_OP_W-1:0] Upr_ALU,
  output logic [REG_AW-1:0]   out_rd_addr,
  output logic                out_rd_we,
  input  logic                wb_en,
  input  logic [REG_AW-1:0]   wb_addr,
  input  logic [XLEN-1:0]     wb_data
);

  logic [XLEN-1:0]     rdata1_w, rdata2_w;
  logic [NREG-1:0]     busy_q, busy_d;
  slot_state_e         state_q, state_d;
  logic [XLEN-1:0]     a_q, b_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [REG_AW-1:0]   rd_q;
  logic                rd_we_q;
  logic                byp1_w, byp2_w, hazard_w, accept_w;

  reg_file_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .raddr1_i  (rs1_addr),
    .raddr2_i  (rs2_addr),
    .rdata1_o  (rdata1_w),
    .rdata2_o  (rdata2_w),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data)
  );

  // A busy source is released in the very cycle its write-back arrives.
  assign byp1_w   = wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0);
  assign byp2_w   = wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0);
  assign hazard_w = ((a_sel == A_SEL_RS1) && busy_q[rs1_addr] && !byp1_w) ||
                    ((b_sel == B_SEL_RS2) && busy_q[rs2_addr] && !byp2_w);
  assign out_valid = (state_q == SLOT_FULL);
  assign in_ready  = (!out_valid || out_ready) && !hazard_w;
  assign accept_w  = in_valid && in_ready;

  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    // Setting after clearing lets the younger producer win on a collision.
    if (accept_w && rd_we && (rd_addr != '0)) busy_d[rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept_w) state_d = SLOT_FULL;
      SLOT_FULL:  if (accept_w) state_d = SLOT_FULL;
                  else if (out_ready) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      busy_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (accept_w) begin
        a_q     <= (a_sel == A_SEL_PC)  ? pc  : rdata1_w;
        b_q     <= (b_sel == B_SEL_IMM) ? imm : rdata2_w;
        op_q    <= alu_op;
        rd_q    <= rd_addr;
        rd_we_q <= rd_we;
      end
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign Upr_ALU     = op_q;
  assign out_rd_addr = rd_q;
  assign out_rd_we   = rd_we_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_operand_stage
// Brief  : Directed plus random self-checking bench with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, rd_we, a_sel, b_sel;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] pc, imm;
  logic [3:0]  alu_op;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic [3:0]  Upr_ALU;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural register array, busy set, one-entry slot.
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_v;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_we;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_we(rd_we),
    .a_sel(a_sel), .b_sel(b_sel), .pc(pc), .imm(imm), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .Upr_ALU(Upr_ALU),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
    m_v = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_we = 1'b0;
  endtask

  function automatic logic [31:0] rval(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic blocked(input logic [4:0] r);
    return m_busy[r] && !(wb_en && wb_addr == r && r != 0);
  endfunction

  function automatic logic model_ready();
    logic hz;
    hz = (!a_sel && blocked(rs1_addr)) || (!b_sel && blocked(rs2_addr));
    return (!m_v || out_ready) && !hz;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, m_v});
    chk({tag, ".A"}, A, m_a);
    chk({tag, ".B"}, B, m_b);
    chk({tag, ".Upr_ALU"}, {28'b0, Upr_ALU}, {28'b0, m_op});
    chk({tag, ".rd"}, {27'b0, out_rd_addr}, {27'b0, m_rd});
    chk({tag, ".rd_we"}, {31'b0, out_rd_we}, {31'b0, m_we});
  endtask

  // One clock: check in_ready, advance the model at the edge, check outputs.
  task automatic cycle(input string tag);
    logic exp_rdy, acc;
    #1;
    exp_rdy = model_ready();
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (acc) begin
      m_v  = 1;
      m_a  = a_sel ? pc  : rval(rs1_addr);
      m_b  = b_sel ? imm : rval(rs2_addr);
      m_op = alu_op; m_rd = rd_addr; m_we = rd_we;
    end else if (out_ready) begin
      m_v = 0;
    end
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    if (wb_en) m_busy[wb_addr] = 0;
    if (acc && rd_we && rd_addr != 0) m_busy[rd_addr] = 1;
    #1;
    chk_outs(tag);
  endtask

  task automatic idle();
    in_valid = 0; rd_we = 0; wb_en = 0; a_sel = 0; b_sel = 1;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; pc = 0; imm = 0; alu_op = 0;
    wb_addr = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic asel,
                       input logic bsel, input logic [4:0] rd, input logic we,
                       input logic [31:0] p, input logic [31:0] im, input logic [3:0] op);
    in_valid = 1; rs1_addr = rs1; rs2_addr = rs2; a_sel = asel; b_sel = bsel;
    rd_addr = rd; rd_we = we; pc = p; imm = im; alu_op = op;
  endtask

  initial begin
    rst = 0;
    idle();
    model_reset();
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #3 rst = 0;
    chk_outs("reset");

    // Write-back x5 then consume it through the immediate path.
    wb_en = 1; wb_addr = 5; wb_data = 32'hAA;
    cycle("wb_x5");
    idle();
    issue(5, 0, 0, 1, 0, 0, 0, 32'h10, 4'd0);
    cycle("add_x5");
    chk("add_x5.A_const", A, 32'hAA);
    chk("add_x5.B_const", B, 32'h10);

    // x0 is never written and never becomes busy.
    idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    issue(0, 0, 0, 1, 0, 1, 0, 0, 4'd1);
    cycle("x0_wb");
    idle(); issue(0, 0, 0, 0, 0, 0, 0, 0, 4'd2);
    cycle("x0_read");
    chk("x0_read.A_const", A, 32'h0);

    // RAW hazard on x3, released by bypass in the write-back cycle.
    idle(); issue(1, 2, 0, 0, 3, 1, 0, 0, 4'd3);
    cycle("prod_x3");
    idle(); issue(3, 0, 0, 1, 4, 1, 0, 32'h5, 4'd4);
    cycle("stall_x3");
    chk("stall_x3.in_ready_const", {31'b0, in_ready}, 32'h0);
    wb_en = 1; wb_addr = 3; wb_data = 32'h1234;
    cycle("bypass_x3");
    chk("bypass_x3.A_const", A, 32'h1234);

    // Downstream stall holds outputs, then back-to-back replacement.
    idle(); out_ready = 0; issue(5, 0, 0, 1, 6, 0, 0, 32'h77, 4'd5);
    for (int i = 0; i < 3; i++) cycle("hold");
    chk("hold.A_const", A, 32'h1234);
    out_ready = 1;
    cycle("b2b");
    chk("b2b.valid_const", {31'b0, out_valid}, 32'h1);
    chk("b2b.A_const", A, 32'hAA);

    // Sources unused when A=pc and B=imm, even if rs1 is busy.
    idle(); issue(1, 1, 0, 1, 7, 1, 0, 0, 4'd6);
    cycle("prod_x7");
    idle(); issue(7, 7, 1, 1, 0, 0, 32'h100, 32'hFFFF_FFFC, 4'd7);
    cycle("pc_imm");
    chk("pc_imm.A_const", A, 32'h100);
    chk("pc_imm.B_const", B, 32'hFFFF_FFFC);

    // Asynchronous reset with a full slot and x3 busy.
    idle(); issue(0, 0, 0, 1, 3, 1, 0, 32'h9, 4'd8);
    cycle("prod_x3b");
    idle(); out_ready = 0; a_sel = 0; rs1_addr = 3;
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst.out_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst.A", A, 32'h0);
    chk("async_rst.in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #3 rst = 0;
    idle(); issue(3, 3, 0, 0, 0, 0, 0, 0, 4'd9);
    cycle("post_rst");
    chk("post_rst.A_const", A, 32'h0);

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      rd_addr   = 5'($urandom_range(0, 7));
      rd_we     = 1'($urandom_range(0, 1));
      a_sel     = ($urandom_range(0, 3) == 0);
      b_sel     = ($urandom_range(0, 3) == 0);
      pc        = $urandom;
      imm       = $urandom;
      alu_op    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the ALU. Holds the 32×32 integer register file, selects the ALU operands A/B (register, immediate or PC) and the 4-bit ALU opcode, and presents them to the ALU from a registered output slot with valid/ready handshaking. Write-back bypass and a per-register busy scoreboard keep read-after-write hazards out of the ALU.

## Interface
Parameters:
- `XLEN`, 32: data width of registers, operands and immediates.
- `NREG`, 32: number of architectural registers; register 0 reads as zero.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `rs1_addr`, `rs2_addr`  in  5 each  source register indices.
- `rd_addr`  in  5  destination register index.
- `rd_we`  in  1  instruction will write `rd_addr` at write-back.
- `a_sel`  in  1  0 = A from rs1, 1 = A from `pc`.
- `b_sel`  in  1  0 = B from rs2, 1 = B from `imm`.
- `pc`, `imm`  in  XLEN each  program counter and sign-extended immediate.
- `alu_op`  in  4  ALU opcode: ADD=0 … GEU=15.
- `out_valid`  out  1  operand slot full.
- `out_ready`  in  1  ALU side consumes the slot this cycle.
- `A`, `B`  out  XLEN each  registered ALU operands.
- `Upr_ALU`  out  4  registered ALU opcode.
- `out_rd_addr`, `out_rd_we`  out  5, 1  forwarded to write-back.
- `wb_en`, `wb_addr`, `wb_data`  in  1, 5, XLEN  write-back port.

## Operation
- Register file: write on `wb_en` when `wb_addr != 0`. Register 0 is never written and always reads 0.
- Read with write-first bypass: if `wb_en` and `wb_addr == rsN` and `rsN != 0`, the read returns `wb_data` in the same cycle.
- Scoreboard `busy[NREG-1:0]`:
  - Set bit `rd_addr` on accept when `rd_we` and `rd_addr != 0`.
  - Clear bit `wb_addr` on `wb_en`.
  - Same-cycle set and clear of the same index: set wins, because the new producer is younger.
  - Bit 0 is always 0.
- Hazard: a source is blocked if it is used (rs1 when `a_sel=0`, rs2 when `b_sel=0`), its busy bit is set, and it is not being bypassed this cycle.
- Accept: `in_ready = (!out_valid || out_ready) && !hazard`. Handshake completes on `in_valid && in_ready`.
- On accept: load `A`, `B`, `Upr_ALU`, `out_rd_addr`, `out_rd_we`, and set `out_valid`.
- Slot drains on `out_valid && out_ready` with no accept: `out_valid` goes to 0 and data regs hold their value.
- Slot state machine:
  - EMPTY → FULL on accept.
  - FULL → FULL on drain plus accept in the same cycle (back-to-back, no bubble).
  - FULL → EMPTY on drain only.
  - FULL holds on stall.
- While `out_valid && !out_ready`, outputs are stable.
- No arithmetic in this stage. Widths pass through unchanged; `imm` is already sign-extended.

## Timing
- Reset values: `out_valid`=0, `A`=`B`=0, `Upr_ALU`=0 (ADD), `out_rd_addr`=0, `out_rd_we`=0, all registers 0, `busy`=0.
- Reset asserted mid-operation discards the slot and the scoreboard immediately, without waiting for a clock edge.
- Latency: one cycle from accept to `out_valid`. Throughput is 1 per cycle with no hazards.
- `in_ready` is combinational from `out_ready`, `busy`, `wb_*` and the source fields. There is no combinational path from `in_valid` to `in_ready`.
- Hazard stall lasts until the cycle whose `wb_en` writes the blocking register; the instruction is accepted in that same cycle via bypass.

## Structure
- Shared package, used by the decoder and the ALU: ALU opcode constants ADD…GEU (0–15), `XLEN`, register-index width 5, `a_sel`/`b_sel` encodings.
- One sub-module: `reg_file_2r1w`, with 2 combinational read ports, 1 synchronous write port, x0 hardwired to zero and the bypass logic. The scoreboard, hazard logic and slot live in the top level.

## Test plan
- Reset, write-back x5=0x0000_00AA, then issue ADD with rs1=x5, `b_sel`=1, imm=0x10 → next cycle `out_valid`=1, A=0xAA, B=0x10, `Upr_ALU`=0.
- Issue rs1=x0 after `wb_en` to x0 with 0xFFFF_FFFF → A=0, and x0 is never marked busy.
- Issue instr1 (rd=x3, `rd_we`=1), then instr2 reading x3 → instr2 stalls (`in_ready`=0). Assert `wb_en`, x3=0x1234 → instr2 is accepted that cycle with A=0x1234.
- Hold `out_ready`=0 with the slot full → `in_ready`=0, and A/B/`Upr_ALU` stay unchanged for 3 cycles. Then `out_ready`=1 with a new `in_valid` → replaced back-to-back with no bubble.
- `a_sel`=1, pc=0x100, `b_sel`=1, imm=0xFFFF_FFFC, with rs1=busy x7 → no stall (sources unused), A=0x100, B=0xFFFF_FFFC.
- Assert `rst` asynchronously while the slot is full and x3 is busy → `out_valid`=0 and `busy`=0 before the next edge; x3 reads 0.
